// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM/IO port between instruction fetch and the LSB,
// serialising multi-byte requests and reassembling read data little-endian.
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LSB_BURST_MAX = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  io_buffer_full,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_pc,
  output logic                  mc_to_if_ready,
  output logic [31:0]           mc_to_if_inst,
  input  logic                  lsb_req_valid,
  input  logic                  lsb_req_wr,
  input  logic [1:0]            lsb_req_size,
  input  logic [ADDR_WIDTH-1:0] lsb_req_addr,
  input  logic [31:0]           lsb_req_data,
  output logic                  mc_to_lsb_ready,
  output logic [31:0]           mc_to_lsb_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);
  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;
  localparam logic [7:0] BMAX = 8'(LSB_BURST_MAX);

  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] addr, cur_a;
  logic [2:0] k, n;
  logic [1:0] bi;
  logic [31:0] data, wdata;
  logic [7:0] burst;
  logic is_if, resume, rd, lsb_win, grant, io_stall, step;

  assign rd = state == IF_RD || state == LS_RD;
  // after a pause the RAM saw the paused address, so re-issue the byte still owed
  assign cur_a = addr + ADDR_WIDTH'(k) - ADDR_WIDTH'(rd && resume);
  assign io_stall = state == LS_WR && io_buffer_full && cur_a[17:16] == 2'b11;
  assign lsb_win = lsb_req_valid && !(burst == BMAX && if_req_valid);
  assign grant = state == IDLE && rdy_in && !flush_in && (lsb_req_valid || if_req_valid);
  assign step = rdy_in && (rd ? !resume && !flush_in : !io_stall);
  assign bi = k[1:0] - 2'd1;

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    if (rdy_in)
      case (state)
        IDLE:         if (grant) nxt = lsb_win ? (lsb_req_wr ? LS_WR : LS_RD) : IF_RD;
        IF_RD, LS_RD: nxt = flush_in ? IDLE : (!resume && k == n) ? DONE : state;
        LS_WR:        if (!io_stall && k == n - 3'd1) nxt = DONE;
        default:      nxt = IDLE;
      endcase
  end

  always_comb begin
    mem_a           = cur_a;
    mem_wr          = state == LS_WR && rdy_in && !io_stall;
    mem_dout        = wdata[{k[1:0], 3'b000} +: 8];
    mc_to_if_ready  = state == DONE && rdy_in && is_if;
    mc_to_lsb_ready = state == DONE && rdy_in && !is_if;
    mc_to_if_inst   = data;
    mc_to_lsb_data  = data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      addr   <= '0;
      k      <= '0;
      n      <= '0;
      data   <= '0;
      wdata  <= '0;
      burst  <= '0;
      is_if  <= 1'b0;
      resume <= 1'b0;
    end else begin
      resume <= !rdy_in;
      if (grant) begin
        is_if <= !lsb_win;
        addr  <= lsb_win ? lsb_req_addr : if_req_pc;
        n     <= (!lsb_win || lsb_req_size[1]) ? 3'd4 : lsb_req_size[0] ? 3'd2 : 3'd1;
        k     <= '0;
        data  <= '0;
        wdata <= lsb_req_data;
        burst <= !lsb_win ? 8'd0 : if_req_valid ? burst + 8'd1 : burst;
      end else if ((rd || state == LS_WR) && step) begin
        k <= k + 3'd1;
        if (rd && k != 3'd0) data[{bi, 3'b000} +: 8] <= mem_din;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a byte-RAM
// model and a rule-level arbitration/transaction model.
module tb_mem_arbiter;
  localparam int BMAX = 2;

  logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0, io_buffer_full = 1'b0;
  logic if_req_valid = 1'b0;
  logic [31:0] if_req_pc = '0;
  logic lsb_req_valid = 1'b0, lsb_req_wr = 1'b0;
  logic [1:0] lsb_req_size = '0;
  logic [31:0] lsb_req_addr = '0, lsb_req_data = '0;
  logic mc_to_if_ready, mc_to_lsb_ready, mem_wr;
  logic [31:0] mc_to_if_inst, mc_to_lsb_data, mem_a;
  logic [7:0] mem_din, mem_dout;

  mem_arbiter #(.ADDR_WIDTH(32), .LSB_BURST_MAX(BMAX)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .io_buffer_full(io_buffer_full),
    .if_req_valid(if_req_valid), .if_req_pc(if_req_pc),
    .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
    .lsb_req_valid(lsb_req_valid), .lsb_req_wr(lsb_req_wr), .lsb_req_size(lsb_req_size),
    .lsb_req_addr(lsb_req_addr), .lsb_req_data(lsb_req_data),
    .mc_to_lsb_ready(mc_to_lsb_ready), .mc_to_lsb_data(mc_to_lsb_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [0:65535];
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  int n_cmp = 0, n_err = 0, bc = 0;
  bit iv = 0, lv = 0, ls_wr = 0;
  logic [31:0] if_pc = '0, ls_addr = '0, ls_data = '0;
  logic [1:0] ls_size = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r, x;
    r = '0;
    for (int i = 0; i < n; i++) begin
      x = a + 32'(i);
      r[8*i +: 8] = ram[x[15:0]];
    end
    return r;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction

  // Entered in cycle 0 (just after the accept edge); strict mode checks every cycle's port values.
  task automatic run_txn(input bit is_if, input bit wr, input int n, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp, input bit strict,
                         input int flush_at, input int io_cycles);
    bit done;
    int e;
    logic ready;
    logic [31:0] rdata, x;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      rdy_in = strict ? 1'b1 : ($urandom_range(0, 2) != 0);
      flush_in = (c == flush_at);
      io_buffer_full = (c < io_cycles);
      #1;
      chk("ready_excl", {31'b0, mc_to_if_ready & mc_to_lsb_ready}, 0);
      ready = is_if ? mc_to_if_ready : mc_to_lsb_ready;
      rdata = is_if ? mc_to_if_inst : mc_to_lsb_data;
      if (!rdy_in) chk("pause_wr", {31'b0, mem_wr}, 0);
      if (strict) begin
        e = c - io_cycles;
        if (!wr && c == flush_at) begin chk("flush_rdy", {31'b0, ready}, 0); done = 1; end
        else if (!wr && c < n) begin
          chk("rd_addr", mem_a, a + 32'(c));
          chk("rd_rdy", {31'b0, ready}, 0);
          chk("rd_wr", {31'b0, mem_wr}, 0);
        end
        else if (!wr && c == n) chk("rd_rdy_last", {31'b0, ready}, 0);
        else if (!wr) begin
          chk("rd_done", {31'b0, ready}, 1);
          chk("rd_data", rdata, exp);
          done = 1;
        end
        else if (e < 0) begin
          chk("io_stall_wr", {31'b0, mem_wr}, 0);
          chk("wr_rdy", {31'b0, ready}, 0);
        end
        else if (e < n) begin
          chk("wr_en", {31'b0, mem_wr}, 1);
          chk("wr_addr", mem_a, a + 32'(e));
          chk("wr_data", {24'b0, mem_dout}, {24'b0, d[8*e +: 8]});
          chk("wr_rdy", {31'b0, ready}, 0);
        end
        else begin
          chk("wr_done", {31'b0, ready}, 1);
          chk("wr_en_done", {31'b0, mem_wr}, 0);
          done = 1;
        end
      end else if (ready) begin
        if (!wr) chk("rd_data_paused", rdata, exp);
        done = 1;
      end
      if (!done) begin @(posedge clk_in); #1; end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $error("FAIL timeout: no ready within 300 cycles");
    end
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    io_buffer_full = 1'b0;
    rdy_in = 1'b1;
    if (is_if) if_req_valid = 1'b0; else lsb_req_valid = 1'b0;
    #1;
    chk("if_pulse_end", {31'b0, mc_to_if_ready}, 0);
    chk("lsb_pulse_end", {31'b0, mc_to_lsb_ready}, 0);
    if (wr) for (int i = 0; i < n; i++) begin
      x = a + 32'(i);
      chk("ram_byte", {24'b0, ram[x[15:0]]}, {24'b0, d[8*i +: 8]});
    end
  endtask

  // Called in an IDLE cycle; arbitration decided from the rules with a plain counter.
  task automatic do_round(input bit strict, input int flush_at, input int io_cycles);
    bit lw;
    int n;
    logic [31:0] a, exp;
    if_req_valid = iv; if_req_pc = if_pc;
    lsb_req_valid = lv; lsb_req_wr = ls_wr; lsb_req_size = ls_size;
    lsb_req_addr = ls_addr; lsb_req_data = ls_data;
    lw = lv && !(bc == BMAX && iv);
    bc = lw ? (iv ? bc + 1 : bc) : 0;
    n = lw ? nbytes(ls_size) : 4;
    a = lw ? ls_addr : if_pc;
    exp = (lw && ls_wr) ? 32'h0 : model_read(a, n);
    @(posedge clk_in); #1;
    run_txn(!lw, lw && ls_wr, n, a, ls_data, exp, strict, flush_at, io_cycles);
    if (lw) lv = 0; else iv = 0;
  endtask

  task automatic set_lsb(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    lv = 1; ls_wr = wr; ls_size = sz; ls_addr = a; ls_data = d;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
    ram[16'h1000] <= 8'h13; ram[16'h1001] <= 8'h05; ram[16'h1002] <= 8'h00; ram[16'h1003] <= 8'h00;
    #2;
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    chk("rst_if_rdy", {31'b0, mc_to_if_ready}, 0);
    chk("rst_lsb_rdy", {31'b0, mc_to_lsb_ready}, 0);
    chk("rst_lsb_data", mc_to_lsb_data, 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    #1;
    // fetch of a known instruction
    iv = 1; if_pc = 32'h1000;
    do_round(1, -1, 0);
    chk("t1_inst", mc_to_if_inst, 32'h0000_0513);
    // simultaneous requests: LSB first, then the waiting fetch
    iv = 1; if_pc = 32'h1000;
    set_lsb(0, 2'b01, 32'h2002, 0);
    do_round(1, -1, 0);
    do_round(1, -1, 0);
    // continuous LSB pressure with IF waiting
    iv = 1; if_pc = 32'h1004;
    for (int r = 0; r < 6; r++) begin
      if (!iv) begin iv = 1; if_pc = 32'h1008 + 32'(r * 4); end
      set_lsb(0, 2'b10, 32'h2100 + 32'(r * 16), 0);
      do_round(1, -1, 0);
    end
    if (lv) do_round(1, -1, 0);
    if (iv) do_round(1, -1, 0);
    // flush mid-fetch, then a request served immediately
    iv = 1; if_pc = 32'h1800;
    do_round(1, 2, 0);
    set_lsb(0, 2'b00, 32'h2300, 0);
    do_round(1, -1, 0);
    // flush during a committed store
    set_lsb(1, 2'b10, 32'h2400, 32'hA1B2C3D4);
    do_round(1, 1, 0);
    // IO-space store stalled by a full UART buffer
    set_lsb(1, 2'b00, 32'h0003_0000, 32'hABCDEF41);
    do_round(1, -1, 3);
    // address wrap
    set_lsb(0, 2'b01, 32'hFFFF_FFFF, 0);
    do_round(1, -1, 0);
    set_lsb(1, 2'b10, 32'hFFFF_FFFE, 32'h5566_7788);
    do_round(1, -1, 0);
    // randomized traffic, some with rdy_in pauses
    for (int r = 0; r < 40; r++) begin
      if (!iv && $urandom_range(0, 1) == 1) begin iv = 1; if_pc = 32'($urandom_range(0, 16383)) << 2; end
      if (!lv && ($urandom_range(0, 2) != 0 || !iv))
        set_lsb(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {16'h0001, 16'($urandom)}, $urandom);
      do_round($urandom_range(0, 2) != 0, -1, 0);
    end
    while (iv || lv) do_round(0, -1, 0);
    // asynchronous reset in the middle of a store
    lsb_req_valid = 1'b1; lsb_req_wr = 1'b1; lsb_req_size = 2'b10;
    lsb_req_addr = 32'h2500; lsb_req_data = 32'hDEADBEEF;
    @(posedge clk_in); #2;
    chk("pre_rst_wr", {31'b0, mem_wr}, 1);
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_wr", {31'b0, mem_wr}, 0);
    chk("async_rst_rdy", {31'b0, mc_to_lsb_ready}, 0);
    chk("async_rst_a", mem_a, 0);
    lsb_req_valid = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1; bc = 0;
    #1;
    set_lsb(0, 2'b10, 32'h2600, 0);
    do_round(1, -1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
